// File: rtl/uart_cmd_queue_if.sv
// Host-side bundle for uart_cmd_queue: FIFO push/status, overflow control and the serial line.
// master = command producer / line observer, slave = the transmitter block.
interface uart_cmd_queue_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              full;
    logic              empty;
    logic [OCC_W-1:0]  count;
    logic              overflow;
    logic              clr_ovf;
    logic              TX;
    logic              tx_busy;
    logic              cmd_sent;

    modport master (
        output push, push_data, clr_ovf,
        input  full, empty, count, overflow, TX, tx_busy, cmd_sent
    );

    modport slave (
        input  push, push_data, clr_ovf,
        output full, empty, count, overflow, TX, tx_busy, cmd_sent
    );
endinterface

// File: rtl/uart_cmd_queue.sv
// Queued 8N1-style UART command transmitter: a DEPTH-entry FIFO feeding a frame serialiser
// with optional idle gap. Define UART_PARITY_EN to add an even-parity bit after the data bits.
module uart_cmd_queue #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int BAUD_DIV = 2604,
    parameter int GAP_BITS = 0
) (
    input  logic              clk,
    input  logic              rst,
    uart_cmd_queue_if.slave   bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int GAP_MAX = (GAP_BITS > 0) ? GAP_BITS : 1;
    localparam int CNT_W   = (BAUD_DIV * GAP_MAX > 1) ? $clog2(BAUD_DIV * GAP_MAX) : 1;
    localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_RELOAD  = CNT_W'(GAP_MAX * BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_W - 1);
    localparam logic [OCC_W-1:0] FULL_OCC    = OCC_W'(DEPTH);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
`endif

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d;
`ifdef UART_PARITY_EN
    logic              par_q, par_d;
`endif

    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              sent_q, sent_d;

    logic              pop;
    logic              is_full;
    logic              push_ok;
    logic              baud_done;

    // FIFO bookkeeping; a pop only ever happens from IDLE with data waiting.
    always_comb begin
        pop      = (state_q == IDLE) && (count_q != '0);
        is_full  = (count_q == FULL_OCC);
        push_ok  = bus.push && (!is_full || pop);

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + OCC_W'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - OCC_W'(1);
        end

        // An overflowing push beats a same-cycle clear.
        ovf_d = ovf_q;
        if (bus.push && is_full && !pop) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        sent_d    = 1'b0;
        baud_done = (baud_q == '0);
`ifdef UART_PARITY_EN
        par_d     = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = START;
                    sh_d    = mem_q[rd_ptr_q];
                    baud_d  = BAUD_RELOAD;
                    bit_d   = '0;
`ifdef UART_PARITY_EN
                    par_d   = ^mem_q[rd_ptr_q];
`endif
                end
            end
            START: begin
                if (baud_done) begin
                    state_d = DATA;
                    baud_d  = BAUD_RELOAD;
                end else begin
                    baud_d  = baud_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    sh_d   = sh_q >> 1;
                    baud_d = BAUD_RELOAD;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    state_d = STOP;
                    baud_d  = BAUD_RELOAD;
                end else begin
                    baud_d  = baud_q - CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    sent_d = 1'b1;
                    if (GAP_BITS > 0) begin
                        state_d = GAP;
                        baud_d  = GAP_RELOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (baud_done) begin
                    state_d = IDLE;
                end else begin
                    baud_d  = baud_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line outputs are registered from the current state, so TX trails the FSM by one clock.
    always_comb begin
        busy_d = (state_q != IDLE);
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_q[0];
`ifdef UART_PARITY_EN
            PARITY:  tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= bus.push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
`ifdef UART_PARITY_EN
            par_q    <= 1'b0;
`endif
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            sent_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
`ifdef UART_PARITY_EN
            par_q    <= par_d;
`endif
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            sent_q   <= sent_d;
        end
    end

    assign bus.full     = is_full;
    assign bus.empty    = (count_q == '0);
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
    assign bus.TX       = tx_q;
    assign bus.tx_busy  = busy_q;
    assign bus.cmd_sent = sent_q;

endmodule

// File: tb/tb_uart_cmd_queue.sv
// Bench for uart_cmd_queue: a serial-line monitor decodes each frame and compares it with
// the expected-word queue; directed sequences check latency, FIFO limits, gap and reset.
module tb_uart_cmd_queue;
  localparam int BAUD  = 4;
  localparam int HALF  = BAUD / 2;
  localparam int GAPB  = 2;
  localparam int W     = 9;  // {back_to_back, data[7:0]}
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CLK = NBITS * BAUD;

  logic clk;
  logic rst;

  uart_cmd_queue_if #(.DATA_W(8), .DEPTH(4)) m_if ();
  uart_cmd_queue_if #(.DATA_W(8), .DEPTH(4)) g_if ();

  uart_cmd_queue #(.DATA_W(8), .DEPTH(4), .BAUD_DIV(BAUD), .GAP_BITS(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m_if.slave)
  );

  uart_cmd_queue #(.DATA_W(8), .DEPTH(4), .BAUD_DIV(BAUD), .GAP_BITS(GAPB)) dut_gap (
    .clk (clk),
    .rst (rst),
    .bus (g_if.slave)
  );

  logic [W-1:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge; push lands on the next posedge, returns at the following negedge.
  task automatic drive_push(input logic [7:0] d, input bit expect_sent, input bit b2b);
    m_if.push      = 1'b1;
    m_if.push_data = d;
    if (expect_sent) exp_q.push_back({b2b, d});
    @(negedge clk);
    m_if.push = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_if.tx_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, (n < 2000), 1);
  endtask

  task automatic tick(output bit ab);
    @(negedge clk);
    ab = rst;
  endtask

  // serial-line monitor / scoreboard
  initial begin : monitor
    int           hi_run;
    logic [W-1:0] e;
    logic [7:0]   d;
    logic         par_s, stop_s;
    bit           ab;
    hi_run = 0;
    d = '0;
    par_s = 1'b0;
    stop_s = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hi_run = 0;
      end else if (m_if.TX) begin
        hi_run++;
      end else begin
        ab = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          e = '0;
        end else begin
          e = exp_q[0];
        end
        if (e[8]) check("frame_spacing", hi_run, BAUD + 1);
        for (int i = 0; i < HALF && !ab; i++) tick(ab);
        if (!ab) check("start_bit", m_if.TX, 0);
        for (int b = 0; b < 8 && !ab; b++) begin
          for (int i = 0; i < BAUD && !ab; i++) tick(ab);
          d[b] = m_if.TX;
        end
`ifdef UART_PARITY_EN
        for (int i = 0; i < BAUD && !ab; i++) tick(ab);
        par_s = m_if.TX;
`endif
        for (int i = 0; i < BAUD && !ab; i++) tick(ab);
        stop_s = m_if.TX;
        if (!ab) check("cmd_sent_mid_stop", m_if.cmd_sent, 0);
        for (int i = 0; i < BAUD - 1 - HALF && !ab; i++) tick(ab);
        if (!ab) begin
          check("cmd_sent_end_stop", m_if.cmd_sent, 1);
          check("stop_bit", stop_s, 1);
          check("frame_data", d, e[7:0]);
`ifdef UART_PARITY_EN
          check("parity_bit", par_s, ^e[7:0]);
`endif
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          hi_run = BAUD;
        end else begin
          hi_run = 0;
        end
      end
    end
  end

  initial begin : main
    int n, run, blo, cmd_pos;
    bit bad;
    rst = 1'b1;
    m_if.push = 1'b0; m_if.push_data = '0; m_if.clr_ovf = 1'b0;
    g_if.push = 1'b0; g_if.push_data = '0; g_if.clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", m_if.TX, 1);
    check("rst_busy", m_if.tx_busy, 0);
    check("rst_cmd_sent", m_if.cmd_sent, 0);
    check("rst_overflow", m_if.overflow, 0);
    check("rst_count", m_if.count, 0);
    check("rst_empty", m_if.empty, 1);
    check("rst_full", m_if.full, 0);
    check("rst_gap_tx", g_if.TX, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single 'G': latency and cmd_sent position
    m_if.push = 1'b1; m_if.push_data = 8'h47;
    exp_q.push_back({1'b0, 8'h47});
    @(negedge clk);                       // index 0 (after push edge)
    m_if.push = 1'b0;
    check("t1_count_after_push", m_if.count, 1);
    check("t1_tx_idx0", m_if.TX, 1);
    @(negedge clk);                       // index 1
    check("t1_count_after_pop", m_if.count, 0);
    check("t1_tx_idx1", m_if.TX, 1);
    @(negedge clk);                       // index 2
    check("t1_tx_falls", m_if.TX, 0);
    check("t1_busy", m_if.tx_busy, 1);
    repeat (FRAME_CLK - 2) @(negedge clk);
    check("t1_cmd_sent_early", m_if.cmd_sent, 0);
    @(negedge clk);
    check("t1_cmd_sent_pulse", m_if.cmd_sent, 1);
    @(negedge clk);
    check("t1_cmd_sent_drop", m_if.cmd_sent, 0);
    check("t1_busy_done", m_if.tx_busy, 0);
    wait_idle("t1_idle");

    // fill to full, overflow, clear, then push-while-full with a pop
    drive_push(8'h47, 1, 0);
    drive_push(8'h53, 1, 1);
    drive_push(8'h47, 1, 1);
    drive_push(8'h53, 1, 1);
    drive_push(8'hAA, 1, 1);
    drive_push(8'h3C, 0, 0);
    check("t2_full", m_if.full, 1);
    check("t2_count", m_if.count, 4);
    check("t2_overflow", m_if.overflow, 1);
    m_if.clr_ovf = 1'b1;
    @(negedge clk);
    m_if.clr_ovf = 1'b0;
    check("t2_ovf_cleared", m_if.overflow, 0);
    check("t2_still_full", m_if.full, 1);
    n = 0;
    while (!m_if.cmd_sent && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_cmd_wait", (n < 200), 1);
    drive_push(8'h99, 1, 1);
    check("t5_count_same", m_if.count, 4);
    check("t5_full", m_if.full, 1);
    check("t5_no_overflow", m_if.overflow, 0);
    wait_idle("t2_idle");
    check("t2_empty_end", m_if.empty, 1);

    // inter-frame gap on the GAP_BITS=2 instance
    g_if.push = 1'b1; g_if.push_data = 8'h47;
    @(negedge clk);
    g_if.push_data = 8'h53;
    @(negedge clk);
    g_if.push = 1'b0;
    n = 0;
    while (g_if.TX && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t3_start_wait", (n < 100), 1);
    repeat ((NBITS - 1) * BAUD) @(negedge clk);
    run = 0; blo = 0; n = 0; cmd_pos = -1;
    while (g_if.TX && n < 100) begin
      if (!g_if.tx_busy) blo++;
      if (g_if.cmd_sent) cmd_pos = run;
      run++;
      @(negedge clk);
      n++;
    end
    check("t3_high_run", run, BAUD + GAPB * BAUD + 1);
    check("t3_busy_low_cycles", blo, 1);
    check("t3_cmd_sent_pos", cmd_pos, BAUD - 1);
    n = 0;
    while (g_if.tx_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t3_idle", (n < 200), 1);
    check("t3_gap_empty", g_if.empty, 1);

    // reset mid-DATA with words queued
    drive_push(8'h11, 1, 0);
    drive_push(8'h22, 1, 1);
    drive_push(8'h33, 1, 1);
    repeat (BAUD * 3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("t4_tx", m_if.TX, 1);
    check("t4_busy", m_if.tx_busy, 0);
    check("t4_count", m_if.count, 0);
    check("t4_empty", m_if.empty, 1);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < BAUD * 12; i++) begin
      @(negedge clk);
      if (m_if.cmd_sent || !m_if.TX) bad = 1'b1;
    end
    check("t4_quiet_after_reset", bad, 0);

    // parity patterns (odd and even ones)
    drive_push(8'h07, 1, 0);
    drive_push(8'h53, 1, 1);
    wait_idle("t6_idle");
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
